// File: rtl/dp_tap_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encoding and the next-state graph.
package dp_tap_pkg;

  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PA_DR  = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PA_IR  = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_t;

  function automatic tap_state_t tap_next(input tap_state_t state, input logic tms);
    tap_state_t nxt;
    case (state)
      TLR:    nxt = tms ? TLR    : RTI;
      RTI:    nxt = tms ? SEL_DR : RTI;
      SEL_DR: nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR: nxt = tms ? EX1_DR : SH_DR;
      SH_DR:  nxt = tms ? EX1_DR : SH_DR;
      EX1_DR: nxt = tms ? UPD_DR : PA_DR;
      PA_DR:  nxt = tms ? EX2_DR : PA_DR;
      EX2_DR: nxt = tms ? UPD_DR : SH_DR;
      UPD_DR: nxt = tms ? SEL_DR : RTI;
      SEL_IR: nxt = tms ? TLR    : CAP_IR;
      CAP_IR: nxt = tms ? EX1_IR : SH_IR;
      SH_IR:  nxt = tms ? EX1_IR : SH_IR;
      EX1_IR: nxt = tms ? UPD_IR : PA_IR;
      PA_IR:  nxt = tms ? EX2_IR : PA_IR;
      EX2_IR: nxt = tms ? UPD_IR : SH_IR;
      UPD_IR: nxt = tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/dp_tap_fsm.sv
// TAP state register with combinational capture/shift/update strobe decode.
module dp_tap_fsm
  import dp_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);

  tap_state_t state_nxt;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) state <= TLR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = tap_next(state, tms);
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    update_ir  = 1'b0;
    case (state)
      CAP_DR:  capture_dr = 1'b1;
      SH_DR:   shift_dr   = 1'b1;
      UPD_DR:  update_dr  = 1'b1;
      CAP_IR:  capture_ir = 1'b1;
      SH_IR:   shift_ir   = 1'b1;
      UPD_IR:  update_ir  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/dp_tap_ir_core.sv
// TAP core: FSM, instruction register, BYPASS/IDCODE data registers,
// external DR select and a negedge-retimed TDO mux.
module dp_tap_ir_core
  import dp_tap_pkg::*;
#(
  parameter int              IR_W         = 4,
  parameter logic [31:0]     IDCODE       = 32'h1000_563D,
  parameter logic [IR_W-1:0] IDCODE_INSTR = IR_W'(4'hE),
  parameter int              N_EXT        = 2,
  parameter logic [IR_W-1:0] EXT_BASE     = IR_W'(4'h8)
) (
  input  logic             tck,
  input  logic             trst,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             tdo_oe,
  output logic [3:0]       state_out,
  output logic             capture_dr,
  output logic             shift_dr,
  output logic             update_dr,
  output logic             capture_ir,
  output logic             shift_ir,
  output logic             update_ir,
  output logic [IR_W-1:0]  ir_out,
  output logic [N_EXT-1:0] ext_sel,
  input  logic [N_EXT-1:0] ext_tdo
);

  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);

  if (IR_W < 2) begin : g_bad_ir_w
    $error("IR_W must be at least 2");
  end
  if (IDCODE[0] != 1'b1) begin : g_bad_idcode
    $error("IDCODE bit 0 must be 1");
  end
  if ((int'(IDCODE_INSTR) >= int'(EXT_BASE)) &&
      (int'(IDCODE_INSTR) < int'(EXT_BASE) + N_EXT)) begin : g_bad_instr_ext
    $error("IDCODE_INSTR overlaps the external DR range");
  end
  if (IDCODE_INSTR == '1) begin : g_bad_instr_ones
    $error("IDCODE_INSTR must not be all-ones (reserved for BYPASS)");
  end
  if (int'(EXT_BASE) + N_EXT > (2 ** IR_W) - 1) begin : g_bad_ext_range
    $error("external DR range collides with the all-ones BYPASS code");
  end

  tap_state_t      state;
  logic [IR_W-1:0] ir_sr;
  logic            bypass_reg;
  logic [31:0]     idcode_sr;
  logic            sel_idcode;
  logic            sel_bypass;
  logic            dr_tdo;

  dp_tap_fsm u_fsm (
    .tck       (tck),
    .trst      (trst),
    .tms       (tms),
    .state     (state),
    .capture_dr(capture_dr),
    .shift_dr  (shift_dr),
    .update_dr (update_dr),
    .capture_ir(capture_ir),
    .shift_ir  (shift_ir),
    .update_ir (update_ir)
  );

  assign state_out = state;

  // Instruction decode: IDCODE wins, then the external window, else BYPASS.
  always_comb begin
    sel_idcode = (ir_out == IDCODE_INSTR);
    ext_sel    = '0;
    for (int k = 0; k < N_EXT; k++) begin
      if (!sel_idcode && (int'(ir_out) == int'(EXT_BASE) + k)) ext_sel[k] = 1'b1;
    end
    sel_bypass = !sel_idcode && (ext_sel == '0);
  end

  always_comb begin
    dr_tdo = bypass_reg;
    if (sel_idcode) dr_tdo = idcode_sr[0];
    for (int k = 0; k < N_EXT; k++) begin
      if (ext_sel[k]) dr_tdo = ext_tdo[k];
    end
  end

  // Instruction register: only UPD_IR or a move into TLR changes ir_out.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_sr  <= '0;
      ir_out <= IDCODE_INSTR;
    end else begin
      if (capture_ir)    ir_sr <= IR_CAPTURE;
      else if (shift_ir) ir_sr <= {tdi, ir_sr[IR_W-1:1]};
      if (tap_next(state, tms) == TLR) ir_out <= IDCODE_INSTR;
      else if (update_ir)              ir_out <= ir_sr;
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      bypass_reg <= 1'b0;
      idcode_sr  <= IDCODE;
    end else begin
      if (sel_bypass && capture_dr)    bypass_reg <= 1'b0;
      else if (sel_bypass && shift_dr) bypass_reg <= tdi;
      if (sel_idcode && capture_dr)    idcode_sr <= IDCODE;
      else if (sel_idcode && shift_dr) idcode_sr <= {tdi, idcode_sr[31:1]};
    end
  end

  // Falling-edge retime: the bit present after posedge n is driven at negedge n.
  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tdo    <= 1'b0;
      tdo_oe <= 1'b0;
    end else begin
      tdo_oe <= shift_ir || shift_dr;
      if (shift_ir)      tdo <= ir_sr[0];
      else if (shift_dr) tdo <= dr_tdo;
    end
  end

endmodule

// File: tb/tb_dp_tap_ir_core.sv
// Directed bench for dp_tap_ir_core with a per-cycle reference model.
module tb_dp_tap_ir_core;

  localparam logic [31:0] IDC = 32'h1000_563D;

  logic       tck = 1'b0;
  logic       trst = 1'b0;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic [1:0] ext_tdo = 2'b00;
  logic       tdo, tdo_oe;
  logic [3:0] state_out;
  logic       capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;
  logic [3:0] ir_out;
  logic [1:0] ext_sel;

  dp_tap_ir_core dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_oe(tdo_oe),
    .state_out(state_out),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
    .ir_out(ir_out), .ext_sel(ext_sel), .ext_tdo(ext_tdo)
  );

  always #10 tck = ~tck;

  int total = 0, bad = 0, cmp_total = 0, cmp_bad = 0;

  // Transition table indexed by state code: next state for tms=1 / tms=0.
  logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
  logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};

  logic [3:0]  m_state, m_ir, m_ir_sh;
  logic        m_byp, m_tdo, m_oe;
  logic [31:0] m_id;

  function automatic logic is_ext(input logic [3:0] ir);
    return (ir == 4'h8) || (ir == 4'h9);
  endfunction

  always @(posedge tck or posedge trst) begin
    if (trst) begin
      m_state = 4'hF; m_ir = 4'hE; m_ir_sh = 4'h0; m_byp = 1'b0; m_id = IDC;
    end else begin
      if (m_state == 4'hE) m_ir_sh = 4'b0001;
      if (m_state == 4'hA) m_ir_sh = {tdi, m_ir_sh[3:1]};
      if (m_state == 4'hD) m_ir = m_ir_sh;
      if (m_state == 4'h6 && m_ir == 4'hE) m_id = IDC;
      if (m_state == 4'h6 && m_ir != 4'hE && !is_ext(m_ir)) m_byp = 1'b0;
      if (m_state == 4'h2 && m_ir == 4'hE) m_id = {tdi, m_id[31:1]};
      if (m_state == 4'h2 && m_ir != 4'hE && !is_ext(m_ir)) m_byp = tdi;
      m_state = tms ? nxt1[m_state] : nxt0[m_state];
      if (m_state == 4'hF) m_ir = 4'hE;
    end
  end

  always @(negedge tck or posedge trst) begin
    if (trst) begin
      m_tdo = 1'b0; m_oe = 1'b0;
    end else if (m_state == 4'hA) begin
      m_tdo = m_ir_sh[0]; m_oe = 1'b1;
    end else if (m_state == 4'h2) begin
      m_oe = 1'b1;
      if (m_ir == 4'hE)     m_tdo = m_id[0];
      else if (is_ext(m_ir)) m_tdo = ext_tdo[int'(m_ir) - 8];
      else                  m_tdo = m_byp;
    end else begin
      m_oe = 1'b0;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge tck) begin
    logic [5:0] strb, strb_exp;
    logic [1:0] sel_exp;
    #2;
    strb     = {capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir};
    strb_exp = {m_state == 4'h6, m_state == 4'h2, m_state == 4'h5,
                m_state == 4'hE, m_state == 4'hA, m_state == 4'hD};
    sel_exp  = (m_ir == 4'h8) ? 2'b01 : (m_ir == 4'h9) ? 2'b10 : 2'b00;
    cmp_total++;
    if (state_out !== m_state || ir_out !== m_ir || ext_sel !== sel_exp ||
        tdo !== m_tdo || tdo_oe !== m_oe || strb !== strb_exp) begin
      cmp_bad++;
      $display("FAIL cycle t=%0t got st=%h ir=%h sel=%b tdo=%b oe=%b strb=%b want st=%h ir=%h sel=%b tdo=%b oe=%b strb=%b",
               $time, state_out, ir_out, ext_sel, tdo, tdo_oe, strb,
               m_state, m_ir, sel_exp, m_tdo, m_oe, strb_exp);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    @(negedge tck);
    #4;
  endtask

  // From RTI: shift v (LSB first) into the IR, update, return to RTI.
  task automatic load_ir(input logic [3:0] v);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, v[i]);
    step(1, 0); step(0, 0);
  endtask

  task automatic goto_shdr();
    step(1, 0); step(0, 0); step(0, 0);
  endtask

  task automatic bypass_run(input string name);
    logic [3:0] pat, exp;
    pat = 4'b1101;
    exp = 4'b1010;
    goto_shdr();
    for (int i = 0; i < 4; i++) begin
      check(name, tdo, exp[i]);
      step(i == 3, pat[i]);
    end
    check({name, "_oe_off"}, tdo_oe, 1'b0);
    step(1, 0); step(0, 0);
  endtask

  initial begin
    logic [31:0] id_bits;
    logic [3:0]  ir_bits;
    logic [15:0] path;

    #1 trst = 1'b1;
    @(negedge tck); #4;
    check("rst_state", state_out, 4'hF);
    check("rst_ir", ir_out, 4'hE);
    check("rst_tdo", tdo, 1'b0);
    check("rst_oe", tdo_oe, 1'b0);
    #1 trst = 1'b0;

    // IDCODE read straight after reset
    step(0, 0);
    goto_shdr();
    id_bits = '0;
    for (int i = 0; i < 32; i++) begin
      id_bits[i] = tdo;
      check("idcode_oe_on", tdo_oe, 1'b1);
      step(i == 31, 0);
    end
    check("idcode_value", id_bits, 32'h1000_563D);
    check("idcode_oe_off", tdo_oe, 1'b0);
    step(1, 0); step(0, 0);

    // IR capture pattern and load of 4'h9
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    ir_bits = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      id_bits[i] = tdo;
      step(i == 3, ir_bits[i]);
    end
    check("ir_capture", id_bits[1:0], 2'b01);
    step(1, 0); step(0, 0);
    check("ir_load9", ir_out, 4'h9);
    check("ext_sel9", ext_sel, 2'b10);

    // External DR 0
    load_ir(4'h8);
    ext_tdo = 2'b01;
    goto_shdr();
    check("ext0_tdo1", tdo, 1'b1);
    check("ext0_sel", ext_sel, 2'b01);
    check("ext0_shift_dr", shift_dr, 1'b1);
    ext_tdo = 2'b10;
    step(0, 0);
    check("ext0_tdo0", tdo, 1'b0);
    step(1, 0); step(1, 0); step(0, 0);
    ext_tdo = 2'b00;

    load_ir(4'hF);
    check("byp_ir_f", ir_out, 4'hF);
    bypass_run("bypass_f");
    load_ir(4'h3);
    check("byp_ir_3", ir_out, 4'h3);
    bypass_run("bypass_3");

    // Pause/resume during IR shift
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(0, 0); step(1, 1);
    step(0, 0);
    for (int i = 0; i < 3; i++) begin
      check("pause_oe", tdo_oe, 1'b0);
      check("pause_state", state_out, 4'hB);
      if (i < 2) step(0, 0);
    end
    step(1, 0); step(0, 0);
    step(0, 1); step(1, 0);
    step(1, 0); step(0, 0);
    check("pause_ir", ir_out, 4'h6);

    // Reset in the middle of a DR shift
    load_ir(4'hF);
    goto_shdr();
    step(0, 1); step(0, 1);
    trst = 1'b1;
    #1;
    check("abort_dr_state", state_out, 4'hF);
    check("abort_dr_ir", ir_out, 4'hE);
    check("abort_dr_oe", tdo_oe, 1'b0);
    #1 trst = 1'b0;

    // Reset in the middle of an IR shift discards the partial value
    step(0, 0);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(0, 0);
    trst = 1'b1;
    #1;
    check("abort_ir_ir", ir_out, 4'hE);
    #1 trst = 1'b0;
    step(0, 0);
    check("abort_ir_rti", ir_out, 4'hE);

    // Five tms=1 clocks reach TLR from every state
    path = 16'b1100_1011_1101_0010;
    for (int k = 0; k <= 16; k++) begin
      for (int j = 0; j < 5; j++) step(1, 0);
      for (int j = 0; j < k; j++) step(path[j], 0);
      for (int j = 0; j < 5; j++) step(1, 0);
      check("tlr_lockout", state_out, 4'hF);
    end

    total += cmp_total;
    bad   += cmp_bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
